// File: rtl/crc8_pkg.sv
// rtl/crc8_pkg.sv - shared CRC-8 constants and table reference function
package crc8_pkg;

  localparam logic [7:0] CRC8_POLY    = 8'h07;
  localparam logic [7:0] CRC8_INIT    = 8'h00;
  localparam logic [7:0] CRC8_XOR_OUT = 8'h00;
  localparam int         NUM_CH       = 2;

  // MSB-first CRC-8 of a single byte starting from zero; one ROM entry.
  function automatic logic [7:0] table_entry(input logic [7:0] poly, input logic [7:0] idx);
    logic [7:0] c;
    c = idx;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ poly) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc8_table.sv
// rtl/crc8_table.sv - 256-entry CRC-8 lookup ROM with registered output
module crc8_table
  import crc8_pkg::*;
#(
  parameter logic [7:0] POLYNOMIAL = CRC8_POLY
) (
  input  logic       clk_i,
  input  logic [7:0] addr_i,
  output logic [7:0] data_o
);

  logic [7:0] data_q;

  always_ff @(posedge clk_i) begin
    data_q <= table_entry(POLYNOMIAL, addr_i);
  end

  assign data_o = data_q;

endmodule

// File: rtl/crc8_dual_scheduler.sv
// rtl/crc8_dual_scheduler.sv - two byte-stream CRC-8 channels sharing one table ROM
module crc8_dual_scheduler
  import crc8_pkg::*;
#(
  parameter logic [7:0] POLYNOMIAL = CRC8_POLY,
  parameter logic [7:0] INIT       = CRC8_INIT,
  parameter logic [7:0] XOR_OUT    = CRC8_XOR_OUT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] s0_data_i,
  input  logic       s0_valid_i,
  input  logic       s0_last_i,
  output logic       s0_ready_o,
  input  logic [7:0] s1_data_i,
  input  logic       s1_valid_i,
  input  logic       s1_last_i,
  output logic       s1_ready_o,
  output logic [7:0] crc0_o,
  output logic       crc0_valid_o,
  output logic [7:0] crc1_o,
  output logic       crc1_valid_o
);

  logic [NUM_CH-1:0]      valid;
  logic [NUM_CH-1:0]      last;
  logic [NUM_CH-1:0]      elig;
  logic [NUM_CH-1:0]      grant;
  logic [NUM_CH-1:0]      inflight_q;
  logic [NUM_CH-1:0]      last_pend_q;
  logic [NUM_CH-1:0]      crc_valid_q;
  logic [NUM_CH-1:0][7:0] acc_q;
  logic [NUM_CH-1:0][7:0] crc_q;
  logic                   prio_q;
  logic                   rsp_v_q;
  logic                   rsp_ch_q;
  logic [7:0]             rom_addr;
  logic [7:0]             rom_data;

  assign valid = {s1_valid_i, s0_valid_i};
  assign last  = {s1_last_i, s0_last_i};
  assign elig  = valid & ~inflight_q;

  // A channel with a lookup outstanding yields, so the other never stalls behind it.
  always_comb begin
    grant = '0;
    if (rst_ni) begin
      if (elig[0] && (!elig[1] || !prio_q)) begin
        grant[0] = 1'b1;
      end else if (elig[1]) begin
        grant[1] = 1'b1;
      end
    end
  end

  assign s0_ready_o = grant[0];
  assign s1_ready_o = grant[1];
  assign rom_addr   = grant[1] ? (acc_q[1] ^ s1_data_i) : (acc_q[0] ^ s0_data_i);

  crc8_table #(
    .POLYNOMIAL(POLYNOMIAL)
  ) u_table (
    .clk_i (clk_i),
    .addr_i(rom_addr),
    .data_o(rom_data)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      inflight_q  <= '0;
      last_pend_q <= '0;
      crc_valid_q <= '0;
      acc_q       <= {NUM_CH{INIT}};
      crc_q       <= {NUM_CH{INIT ^ XOR_OUT}};
      prio_q      <= 1'b0;
      rsp_v_q     <= 1'b0;
      rsp_ch_q    <= 1'b0;
    end else begin
      crc_valid_q <= '0;
      rsp_v_q     <= |grant;
      rsp_ch_q    <= grant[1];
      if (|grant) begin
        prio_q <= grant[0];
      end
      if (rsp_v_q) begin
        inflight_q[rsp_ch_q] <= 1'b0;
        if (last_pend_q[rsp_ch_q]) begin
          crc_q[rsp_ch_q]       <= rom_data ^ XOR_OUT;
          crc_valid_q[rsp_ch_q] <= 1'b1;
          acc_q[rsp_ch_q]       <= INIT;
        end else begin
          acc_q[rsp_ch_q] <= rom_data;
        end
      end
      for (int k = 0; k < NUM_CH; k++) begin
        if (grant[k]) begin
          inflight_q[k]  <= 1'b1;
          last_pend_q[k] <= last[k];
        end
      end
    end
  end

  assign crc0_o       = crc_q[0];
  assign crc1_o       = crc_q[1];
  assign crc0_valid_o = crc_valid_q[0];
  assign crc1_valid_o = crc_valid_q[1];

`ifdef FORMAL
  always_comb begin
    assert ($onehot0(grant));
    assert ((grant & inflight_q) == '0);
    if (rsp_v_q) begin
      assert (inflight_q[rsp_ch_q]);
    end
  end
`endif

endmodule

// File: tb/tb_crc8_dual_scheduler.sv
// tb/tb_crc8_dual_scheduler.sv - self-checking bench for crc8_dual_scheduler
module tb_crc8_dual_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] d0 = 8'h00, d1 = 8'h00;
  logic       v0 = 1'b0, v1 = 1'b0, l0 = 1'b0, l1 = 1'b0;
  logic       r0, r1, cv0, cv1;
  logic [7:0] c0, c1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  crc8_dual_scheduler dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .s0_data_i   (d0),
    .s0_valid_i  (v0),
    .s0_last_i   (l0),
    .s0_ready_o  (r0),
    .s1_data_i   (d1),
    .s1_valid_i  (v1),
    .s1_last_i   (l1),
    .s1_ready_o  (r1),
    .crc0_o      (c0),
    .crc0_valid_o(cv0),
    .crc1_o      (c1),
    .crc1_valid_o(cv1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Bitwise serial CRC-8, poly 0x07, MSB first.
  function automatic logic [7:0] ref_step(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] x;
    x = c ^ b;
    for (int i = 0; i < 8; i++) x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
    return x;
  endfunction

  // Scoreboard fed by observed handshakes.
  logic [7:0] m_acc[2];
  logic       pend[2];
  logic [7:0] pend_crc[2];
  int         pend_cyc[2];
  int         pulse_cnt[2];
  logic [7:0] last_crc[2];
  int         pulse_cyc[2];
  int         last_acc_cyc[2];
  bit         rec_en = 1'b0;
  int         gseq[$];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 8'h00; pend[k] = 1'b0; pulse_cnt[k] = 0;
      last_crc[k] = 8'h00; pulse_cyc[k] = 0; last_acc_cyc[k] = -10;
    end
  end

  always @(negedge clk) begin
    logic [1:0] vv, rr, ll, cvv;
    logic [7:0] dd[2];
    logic [7:0] cc[2];
    vv = {v1, v0}; rr = {r1, r0}; ll = {l1, l0}; cvv = {cv1, cv0};
    dd[0] = d0; dd[1] = d1; cc[0] = c0; cc[1] = c1;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_acc[k] = 8'h00; pend[k] = 1'b0;
      end
    end else begin
      chk("ready_onehot", {31'd0, rr[0] & rr[1]}, 32'd0);
      chk("pulse_onehot", {31'd0, cvv[0] & cvv[1]}, 32'd0);
      for (int k = 0; k < 2; k++) begin
        if (cvv[k]) begin
          pulse_cnt[k]++;
          last_crc[k]  = cc[k];
          pulse_cyc[k] = cyc;
          chk($sformatf("ch%0d_pulse_expected", k), {31'd0, pend[k]}, 32'd1);
          if (pend[k]) begin
            chk($sformatf("ch%0d_crc_model", k), {24'd0, cc[k]}, {24'd0, pend_crc[k]});
            chk($sformatf("ch%0d_pulse_cycle", k), cyc, pend_cyc[k]);
            pend[k] = 1'b0;
          end
        end
        if (vv[k] && rr[k]) begin
          chk($sformatf("ch%0d_accept_spacing", k), {31'd0, (cyc - last_acc_cyc[k]) >= 2}, 32'd1);
          last_acc_cyc[k] = cyc;
          m_acc[k] = ref_step(m_acc[k], dd[k]);
          if (ll[k]) begin
            chk($sformatf("ch%0d_one_outstanding", k), {31'd0, pend[k]}, 32'd0);
            pend[k] = 1'b1; pend_crc[k] = m_acc[k]; pend_cyc[k] = cyc + 2;
            m_acc[k] = 8'h00;
          end
        end
      end
      if (rec_en) gseq.push_back(r0 ? 0 : (r1 ? 1 : -1));
    end
  end

  task automatic drive(input int ch, input logic v, input logic [7:0] d, input logic l);
    if (ch == 0) begin v0 = v; d0 = d; l0 = l; end
    else begin v1 = v; d1 = d; l1 = l; end
  endtask

  // Caller is positioned just after a rising edge.
  task automatic send(input int ch, input logic [7:0] b[$], input bit with_last, input int gap);
    int n;
    for (int i = 0; i < b.size(); i++) begin
      repeat ($urandom_range(gap, 0)) begin @(posedge clk); #1; end
      drive(ch, 1'b1, b[i], with_last && (i == b.size() - 1));
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(ch == 0 ? r0 : r1) && n < 40);
      if (!(ch == 0 ? r0 : r1)) begin
        chk($sformatf("ch%0d_handshake_timeout", ch), 32'd0, 32'd1);
        @(posedge clk); #1;
        drive(ch, 1'b0, 8'h00, 1'b0);
        return;
      end
      @(posedge clk); #1;
      drive(ch, 1'b0, 8'h00, 1'b0);
    end
  endtask

  typedef struct packed {
    int              ch;
    int              len;
    logic [8:0][7:0] b;
    logic [7:0]      exp;
  } vec_t;

  vec_t       vt[7];
  logic [7:0] q[$];
  logic [7:0] s9[$];
  int         pc0, pc1;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{ch: 0, len: 1, b: 72'h01, exp: 8'h07};
    vt[1] = '{ch: 0, len: 1, b: 72'hFF, exp: 8'hF3};
    vt[2] = '{ch: 0, len: 1, b: 72'h00, exp: 8'h00};
    vt[3] = '{ch: 0, len: 9, b: 72'h393837363534333231, exp: 8'hF4};
    vt[4] = '{ch: 1, len: 1, b: 72'h31, exp: 8'h97};
    vt[5] = '{ch: 1, len: 2, b: 72'h0101, exp: 8'h12};
    vt[6] = '{ch: 1, len: 9, b: 72'h393837363534333231, exp: 8'hF4};
    s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    // Reset state, with both sources requesting.
    v0 = 1'b1; v1 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready0", {31'd0, r0}, 32'd0);
    chk("rst_ready1", {31'd0, r1}, 32'd0);
    chk("rst_crc0", {24'd0, c0}, 32'h00);
    chk("rst_crc1", {24'd0, c1}, 32'h00);
    chk("rst_valid", {30'd0, cv1, cv0}, 32'd0);
    v0 = 1'b0; v1 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed frames.
    for (int i = 0; i < 7; i++) begin
      q.delete();
      for (int j = 0; j < vt[i].len; j++) q.push_back(vt[i].b[j]);
      pc0 = pulse_cnt[vt[i].ch];
      send(vt[i].ch, q, 1'b1, 0);
      repeat (4) @(posedge clk);
      #1;
      chk($sformatf("vec%0d_pulses", i), pulse_cnt[vt[i].ch], pc0 + 1);
      chk($sformatf("vec%0d_crc", i), {24'd0, last_crc[vt[i].ch]}, {24'd0, vt[i].exp});
      chk($sformatf("vec%0d_crc_held", i), {24'd0, (vt[i].ch == 0) ? c0 : c1}, {24'd0, vt[i].exp});
    end

    // Held valid: ready high at N, low at N+1, high again at N+2.
    pc0 = pulse_cnt[0];
    drive(0, 1'b1, 8'h01, 1'b1);
    @(negedge clk); chk("held_ready_N", {31'd0, r0}, 32'd1);
    @(negedge clk); chk("held_ready_N1", {31'd0, r0}, 32'd0);
    @(negedge clk); chk("held_ready_N2", {31'd0, r0}, 32'd1);
    @(posedge clk); #1;
    drive(0, 1'b0, 8'h00, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("held_pulses", pulse_cnt[0], pc0 + 2);
    chk("held_crc", {24'd0, c0}, 32'h07);

    // Both channels continuously valid from reset.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rec_en = 1'b1;
    fork
      send(0, s9, 1'b1, 0);
      send(1, s9, 1'b1, 0);
    join
    rec_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("dual_grant_count", {31'd0, gseq.size() >= 18}, 32'd1);
    for (int i = 0; i < 18 && i < gseq.size(); i++) chk($sformatf("dual_grant%0d", i), gseq[i], i % 2);
    chk("dual_crc0", {24'd0, c0}, 32'hF4);
    chk("dual_crc1", {24'd0, c1}, 32'hF4);
    chk("dual_pulse_skew", pulse_cyc[1] - pulse_cyc[0], 32'd1);

    // Reset after four bytes of a channel 1 frame.
    pc1 = pulse_cnt[1];
    q = '{8'h31, 8'h32, 8'h33, 8'h34};
    send(1, q, 1'b0, 0);
    rst_n = 1'b0;
    v0 = 1'b1; v1 = 1'b1;
    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      chk("midrst_ready", {30'd0, r1, r0}, 32'd0);
      chk("midrst_valid", {30'd0, cv1, cv0}, 32'd0);
      chk("midrst_crc0", {24'd0, c0}, 32'h00);
      chk("midrst_crc1", {24'd0, c1}, 32'h00);
    end
    v0 = 1'b0; v1 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(1, s9, 1'b1, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_pulses", pulse_cnt[1], pc1 + 1);
    chk("midrst_crc_after", {24'd0, c1}, 32'hF4);

    // Random frames and gaps on both channels.
    pc0 = pulse_cnt[0];
    pc1 = pulse_cnt[1];
    fork
      begin
        logic [7:0] rq[$];
        for (int f = 0; f < 500; f++) begin
          rq.delete();
          repeat ($urandom_range(6, 1)) rq.push_back(8'($urandom));
          send(0, rq, 1'b1, 2);
        end
      end
      begin
        logic [7:0] rq[$];
        for (int f = 0; f < 500; f++) begin
          rq.delete();
          repeat ($urandom_range(6, 1)) rq.push_back(8'($urandom));
          send(1, rq, 1'b1, 2);
        end
      end
    join
    repeat (5) @(posedge clk);
    #1;
    chk("rand_pulses0", pulse_cnt[0], pc0 + 500);
    chk("rand_pulses1", pulse_cnt[1], pc1 + 500);
    chk("rand_pending", {30'd0, pend[1], pend[0]}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crc8_dual_scheduler.md
# crc8_dual_scheduler

Shares one synchronous 256-entry `crc8_table` ROM between two independent byte-stream channels and computes a running CRC-8 per channel. The scheduler time-multiplexes table lookups round-robin, keeps a per-channel CRC accumulator, and emits each channel's final CRC at frame end. It sits between the packet framers and the frame-check logic in the trigger path.

## Interface
- `POLYNOMIAL`, 8'h07: CRC-8 polynomial, implied x^8. Passed to the table.
- `INIT`, 8'h00: accumulator value at reset and after each frame.
- `XOR_OUT`, 8'h00: value XORed into the final CRC.
- `clk_i` in 1: the only clock.
- `rst_ni` in 1: reset, synchronous and active-low.
- `s0_data_i` in 8: channel 0 byte.
- `s0_valid_i` in 1: channel 0 byte valid.
- `s0_last_i` in 1: the byte is the last of its frame.
- `s0_ready_o` out 1: channel 0 byte accepted this cycle.
- `s1_data_i`, `s1_valid_i`, `s1_last_i`, `s1_ready_o`: same as above, for channel 1.
- `crc0_o` out 8: channel 0 final CRC, held until the next frame completes.
- `crc0_valid_o` out 1: one-cycle pulse when `crc0_o` updates.
- `crc1_o`, `crc1_valid_o`: same as above, for channel 1.

## Operation
- A byte transfers when `valid` and `ready` are both high. The source must hold `data`, `last` and `valid` stable until the byte transfers.
- Table update for one byte: `crc_next = table[crc_acc ^ data]`.
- **Per-channel state:**
  - `crc_acc[7:0]`
  - `inflight`: a lookup is pending.
  - `last_pend`: the pending lookup belongs to the frame's last byte.
- **Eligibility:** channel k is eligible when `sk_valid_i && !inflight[k]`.
- **Arbiter:** round-robin with a 1-bit priority pointer `prio`.
  - If only one channel is eligible, it is granted.
  - If both are eligible, channel `prio` is granted.
  - After any grant, `prio` becomes the other channel.
  - If nothing is eligible, `prio` is unchanged.
- **Grant actions:**
  - `sk_ready_o` = grant[k], combinational, at most one per cycle.
  - ROM address = `crc_acc[k] ^ sk_data_i`.
  - `inflight[k]` is set and `last_pend[k]` is set to `sk_last_i`.
  - The granted channel ID is registered in `rsp_ch`, along with a response-valid bit `rsp_v`.
- **Response cycle** (cycle after the grant, `rsp_v` = 1), using ROM output `value`:
  - If `last_pend[rsp_ch]` = 0: `crc_acc` = `value`.
  - If `last_pend[rsp_ch]` = 1: `crc_o` = `value ^ XOR_OUT`, `crc_valid_o` pulses, `crc_acc` = `INIT`.
  - In both cases `inflight` is cleared at the same clock edge.
- **Frame length:** a single-byte frame (`last` on the first byte) is legal. Frame length is unbounded and there is no counter.
- **Reset mid-frame:** discards all partial state. No `crc_valid_o` pulse for the aborted frame.
- **Reset values:**
  - `sk_ready_o` = 0 while reset is asserted.
  - `crc0_o` = `crc1_o` = `INIT ^ XOR_OUT`.
  - `crc0_valid_o` = `crc1_valid_o` = 0.
  - `crc_acc` = `INIT`.
  - `inflight` = `last_pend` = 0, `rsp_v` = 0, `prio` = 0.

## Timing
- ROM read latency is 1 cycle, and the ROM output is registered inside `crc8_table`.
- A byte accepted in cycle N updates its accumulator at the end of cycle N+1.
- A last byte accepted in cycle N raises `crc_valid_o` in cycle N+2, and `crc_o` is valid from N+2.
- There is no forwarding: a channel becomes eligible again in cycle N+2. Single-channel throughput is 1 byte every 2 cycles.
- With both channels continuously valid, grants alternate 0,1,0,1. ROM utilisation is 100% and each channel runs at 1 byte per 2 cycles.
- A response for one channel and a grant for the other can occur in the same cycle. They are independent and must not stall each other.
- `crc0_valid_o` and `crc1_valid_o` are never high in the same cycle, because only one lookup is returned per cycle.
- `sk_ready_o` has no combinational path from the other channel's `ready`; it depends on `valid`, `inflight` and `prio` only.

## Structure
- Shared package `crc8_pkg`:
  - Default polynomial, `INIT` and `XOR_OUT` constants.
  - Channel count constant (2).
  - `table_entry` reference function, for use by benches and formal.
- One sub-module instance: `crc8_table` (existing ROM), addressed by the arbiter mux.
- The scheduler is purely sequential control: arbiter, response pipeline register and per-channel accumulators. There is no explicit FSM beyond the `inflight` and `last_pend` flags.
- Under `FORMAL`, assert the following:
  - Grants are one-hot-or-zero.
  - A channel is never granted while its `inflight` is set.
  - `rsp_v` implies `inflight[rsp_ch]`.

## Test plan
- Channel 0 sends a single byte 0x01 with `last` set, channel 1 idle. Expect `crc0_o` = 0x07 and a `crc0_valid_o` pulse exactly 2 cycles after accept. `s0_ready_o` stays low in the following cycle.
- Channel 0 sends single bytes 0xFF then 0x00 as two frames. Expect `crc0_o` = 0xF3, then 0x00, with two pulses.
- Channel 0 sends ASCII "123456789" with `last` on '9'. Expect `crc0_o` = 0xF4, and accepts at most every other cycle.
- Both channels send "123456789" continuously valid from the same cycle. Expect alternating grants starting with channel 0, both CRCs = 0xF4, channel 1's pulse one cycle after channel 0's, and no cycle without a grant.
- Reset is asserted after 4 bytes of a channel 1 frame, then "123456789" is resent. Expect no pulse for the aborted frame, `crc1_o` = 0xF4, and outputs at reset values during reset.
- Random valid gaps on both channels, checked against the `crc8_pkg` reference model over 1000 frames. Expect every CRC to match and no dropped or duplicated bytes.
